// File: rtl/anspwm_pkg.sv
// Shared types and constants for the ANS-PWM quantizer sequencer.
// Pipeline latency is derived from stage count and per-stage latencies.
package anspwm_pkg;

   localparam int SAMPLE_W       = 16;
   localparam int NSTAGES_DEF    = 3;
   localparam int STAGE_LAT_DEF  = 3;
   localparam int ADD_LAT_DEF    = 1;
   localparam int MIN_PERIOD_DEF = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   function automatic int pipe_lat(input int nstages, input int stage_lat, input int add_lat);
      return nstages * stage_lat + add_lat;
   endfunction

endpackage

// File: rtl/anspwm_tokline.sv
// DEPTH-deep 1-bit token shift register: shift_out is shift_in delayed DEPTH clocks.
// Shifts every cycle, no backpressure; empty means no token remains once the output bit leaves.
module anspwm_tokline #(
   parameter int DEPTH = 10
) (
   input  logic clk,
   input  logic rst_n,
   input  logic shift_in,
   output logic shift_out,
   output logic empty
);

   logic [DEPTH-1:0] tok_q;
   logic [DEPTH-1:0] tok_d;

   always_comb begin
      tok_d = {tok_q[DEPTH-2:0], shift_in};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tok_q <= '0;
      end else begin
         tok_q <= tok_d;
      end
   end

   assign shift_out = tok_q[DEPTH-1];
   // The top bit leaves this cycle, so only the lower bits decide whether anything stays in flight.
   assign empty     = ~|tok_q[DEPTH-2:0];

endmodule

// File: rtl/anspwm_seq_ctrl.sv
// ANS-PWM sequencer: launches one buffered target per frame into stage 1, res_valid LAT clocks later.
// One-entry input buffer, s_ready drops when full unless consumed this cycle; closed in DRAIN.
module anspwm_seq_ctrl
   import anspwm_pkg::*;
#(
   parameter int NSTAGES    = NSTAGES_DEF,
   parameter int STAGE_LAT  = STAGE_LAT_DEF,
   parameter int ADD_LAT    = ADD_LAT_DEF,
   parameter int MIN_PERIOD = MIN_PERIOD_DEF
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                enable,
   input  logic [SAMPLE_W-1:0] period,
   input  logic                s_valid,
   input  logic [SAMPLE_W-1:0] s_data,
   output logic                s_ready,
   output logic                st_load,
   output logic [SAMPLE_W-1:0] st_target,
   output logic                frame_start,
   output logic                res_valid,
   output logic                underrun,
   output logic                busy
);

   localparam int                LAT   = pipe_lat(NSTAGES, STAGE_LAT, ADD_LAT);
   localparam logic [SAMPLE_W-1:0] MIN_P = MIN_PERIOD[SAMPLE_W-1:0];
   localparam logic [SAMPLE_W-1:0] ONE   = {{(SAMPLE_W-1){1'b0}}, 1'b1};

   state_t              state_q, state_d;
   logic [SAMPLE_W-1:0] per_q, per_d;
   logic [SAMPLE_W-1:0] cnt_q, cnt_d;
   logic                buf_full_q, buf_full_d;
   logic [SAMPLE_W-1:0] buf_q, buf_d;
   logic [SAMPLE_W-1:0] st_target_q, st_target_d;
   logic                underrun_q, underrun_d;

   logic load;
   logic accept;
   logic tok_empty;

   // Gating with enable keeps a frame boundary that coincides with disable from launching.
   assign load    = (state_q == RUN) && enable && (cnt_q == '0);
   assign s_ready = (state_q != DRAIN) && (!buf_full_q || load);
   assign accept  = s_valid && s_ready;

   always_comb begin
      state_d     = state_q;
      per_d       = per_q;
      cnt_d       = cnt_q;
      buf_full_d  = buf_full_q;
      buf_d       = buf_q;
      st_target_d = st_target_q;
      underrun_d  = underrun_q;

      case (state_q)
         IDLE: begin
            if (enable) begin
               state_d    = RUN;
               per_d      = (period < MIN_P) ? MIN_P : period;
               cnt_d      = '0;
               underrun_d = 1'b0;
            end
         end
         RUN: begin
            if (!enable) begin
               state_d = DRAIN;
               cnt_d   = '0;
            end else if (cnt_q == per_q - ONE) begin
               cnt_d = '0;
            end else begin
               cnt_d = cnt_q + ONE;
            end
         end
         DRAIN: begin
            if (tok_empty) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (load) begin
         if (buf_full_q) begin
            st_target_d = buf_q;
            buf_full_d  = 1'b0;
         end else begin
            underrun_d  = 1'b1;
         end
      end

      // Refill after the load so a same-cycle consume and accept leaves the buffer full.
      if (accept) begin
         buf_d      = s_data;
         buf_full_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         per_q       <= MIN_P;
         cnt_q       <= '0;
         buf_full_q  <= 1'b0;
         buf_q       <= '0;
         st_target_q <= '0;
         underrun_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         per_q       <= per_d;
         cnt_q       <= cnt_d;
         buf_full_q  <= buf_full_d;
         buf_q       <= buf_d;
         st_target_q <= st_target_d;
         underrun_q  <= underrun_d;
      end
   end

   anspwm_tokline #(
      .DEPTH(LAT)
   ) u_tokline (
      .clk      (clk),
      .rst_n    (rst_n),
      .shift_in (load),
      .shift_out(res_valid),
      .empty    (tok_empty)
   );

   assign st_load     = load;
   assign frame_start = load;
   assign st_target   = st_target_q;
   assign underrun    = underrun_q;
   assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_anspwm_seq_ctrl.sv
// Directed bench for anspwm_seq_ctrl: fill, clamp, underrun, drain and mid-frame reset.
module tb_anspwm_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        enable;
   logic [15:0] period;
   logic        s_valid;
   logic [15:0] s_data;
   logic        s_ready;
   logic        st_load;
   logic [15:0] st_target;
   logic        frame_start;
   logic        res_valid;
   logic        underrun;
   logic        busy;

   int n_cmp = 0;
   int n_err = 0;
   int acc;
   logic rv_seen;

   always #5 clk = ~clk;

   anspwm_seq_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable     (enable),
      .period     (period),
      .s_valid    (s_valid),
      .s_data     (s_data),
      .s_ready    (s_ready),
      .st_load    (st_load),
      .st_target  (st_target),
      .frame_start(frame_start),
      .res_valid  (res_valid),
      .underrun   (underrun),
      .busy       (busy)
   );

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%04h expected 0x%04h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n   = 1'b0;
      enable  = 1'b0;
      period  = 16'd0;
      s_valid = 1'b0;
      s_data  = 16'd0;
      #12;
      chk1 ("rst_st_load", st_load, 1'b0);
      chk1 ("rst_frame_start", frame_start, 1'b0);
      chk1 ("rst_res_valid", res_valid, 1'b0);
      chk1 ("rst_underrun", underrun, 1'b0);
      chk1 ("rst_busy", busy, 1'b0);
      chk16("rst_st_target", st_target, 16'h0000);

      // Preload 0x1234 while idle.
      cyc();
      rst_n = 1'b1;
      s_valid = 1'b1;
      s_data  = 16'h1234;
      #1;
      chk1("idle_ready_empty", s_ready, 1'b1);
      cyc();
      s_valid = 1'b0;
      #1;
      chk1("idle_ready_full", s_ready, 1'b0);
      chk1("idle_busy", busy, 1'b0);

      // period=20: load at c0, res_valid at c10, next load at c20.
      enable = 1'b1;
      period = 16'd20;
      cyc();
      #1;
      chk1("c0_st_load", st_load, 1'b1);
      chk1("c0_frame_start", frame_start, 1'b1);
      chk1("c0_busy", busy, 1'b1);
      chk1("c0_ready_on_load", s_ready, 1'b1);
      chk1("c0_underrun", underrun, 1'b0);
      for (int k = 1; k <= 20; k++) begin
         cyc();
         #1;
         if (k == 1) chk16("c1_st_target", st_target, 16'h1234);
         chk1("p20_res_valid", res_valid, (k == 10));
         chk1("p20_st_load", st_load, (k == 20));
         chk1("p20_frame_start", frame_start, (k == 20));
         if (k == 20) chk1("c20_underrun", underrun, 1'b0);
      end
      cyc();
      #1;
      chk1 ("c21_underrun", underrun, 1'b1);
      chk16("c21_st_target_hold", st_target, 16'h1234);
      for (int k = 22; k <= 40; k++) begin
         cyc();
      end
      #1;
      chk1 ("c40_st_load", st_load, 1'b1);
      chk1 ("c40_underrun_sticky", underrun, 1'b1);
      chk16("c40_st_target_hold", st_target, 16'h1234);

      // Drop enable two clocks after the c40 load.
      cyc();
      cyc();
      enable = 1'b0;
      #1;
      chk1("c42_st_load", st_load, 1'b0);
      chk1("c42_busy", busy, 1'b1);
      for (int k = 43; k <= 51; k++) begin
         cyc();
         #1;
         if (k == 43) chk1("drain_ready", s_ready, 1'b0);
         chk1("drain_st_load", st_load, 1'b0);
         chk1("drain_res_valid", res_valid, (k == 50));
         chk1("drain_busy", busy, (k <= 50));
      end
      chk1("idle_ready_after_drain", s_ready, 1'b1);

      // period=3 clamps to 8, s_valid held high.
      period  = 16'd3;
      enable  = 1'b1;
      s_valid = 1'b1;
      s_data  = 16'h0AAA;
      #1;
      chk1("d_m1_ready", s_ready, 1'b1);
      cyc();
      s_data = 16'h0BBB;
      #1;
      chk1("d0_st_load", st_load, 1'b1);
      chk1("d0_underrun_cleared", underrun, 1'b0);
      chk1("d0_ready_on_load", s_ready, 1'b1);
      acc = (s_ready && s_valid) ? 1 : 0;
      for (int k = 1; k <= 17; k++) begin
         cyc();
         if (k == 1) s_data = 16'h0CCC;
         #1;
         if (k == 1)  chk16("d1_st_target", st_target, 16'h0AAA);
         if (k == 9)  chk16("d9_st_target", st_target, 16'h0BBB);
         if (k == 17) chk16("d17_st_target", st_target, 16'h0CCC);
         if (k == 16) chk1("d16_underrun", underrun, 1'b0);
         chk1("p8_st_load", st_load, (k % 8 == 0));
         chk1("p8_frame_start", frame_start, (k % 8 == 0));
         chk1("p8_s_ready", s_ready, (k % 8 == 0));
         if (k < 16 && s_ready && s_valid) acc++;
      end
      chk16("p8_accepts_two_frames", acc[15:0], 16'd2);

      // Reset mid-frame with tokens in flight.
      rst_n   = 1'b0;
      enable  = 1'b0;
      s_valid = 1'b0;
      #1;
      chk1 ("mrst_st_load", st_load, 1'b0);
      chk1 ("mrst_frame_start", frame_start, 1'b0);
      chk1 ("mrst_res_valid", res_valid, 1'b0);
      chk1 ("mrst_underrun", underrun, 1'b0);
      chk1 ("mrst_busy", busy, 1'b0);
      chk16("mrst_st_target", st_target, 16'h0000);
      cyc();
      cyc();
      rst_n = 1'b1;
      rv_seen = 1'b0;
      for (int k = 0; k < 15; k++) begin
         cyc();
         rv_seen = rv_seen | res_valid;
      end
      chk1("mrst_no_res_valid", rv_seen, 1'b0);
      chk1("mrst_idle", busy, 1'b0);

      // First frame after reset with an empty buffer.
      enable = 1'b1;
      period = 16'd8;
      cyc();
      #1;
      chk1("e0_st_load", st_load, 1'b1);
      cyc();
      #1;
      chk16("e1_st_target_zero", st_target, 16'h0000);
      chk1 ("e1_underrun", underrun, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
